// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
package i2c_pkg;

  localparam int   I2C_BYTE_W = 8;
  localparam logic I2C_ACK    = 1'b0;
  localparam logic I2C_NACK   = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus input conditioning: 2-FF synchronizers on SCL/SDA, one history
// stage each, and single-clk pulses for SCL edges and START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda_in,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] first sync stage, [1] synchronized level, [2] previous level
  logic [2:0] scl_sh;
  logic [2:0] sda_sh;

  // Synchronizer chains reset to the idle (released, high) bus level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sh <= 3'b111;
      sda_sh <= 3'b111;
    end else begin
      scl_sh <= {scl_sh[1:0], scl};
      sda_sh <= {sda_sh[1:0], sda_in};
    end
  end

  // Edge and bus-condition decode from synchronized level versus history
  always_comb begin
    sda_lvl   = sda_sh[1];
    scl_rise  = scl_sh[1] & ~scl_sh[2];
    scl_fall  = ~scl_sh[1] & scl_sh[2];
    start_det = ~sda_sh[1] & sda_sh[2] & scl_sh[1];
    stop_det  = sda_sh[1] & ~sda_sh[2] & scl_sh[1];
  end

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a byte-wide register pointer. Address byte, pointer byte,
// then data bytes written to or read from an external register port.
// Optional feature macro: I2C_TGT_AUTOINC_EN -- when defined the pointer
// post-increments after every write strobe and every read-byte load;
// otherwise it stays where the pointer byte put it.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         PTR_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             reg_we,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  input  logic [7:0]       reg_rdata,
  output logic             busy
);

`ifdef I2C_TGT_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda_in   (sda_in),
    .sda_lvl  (sda_lvl),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_tgt_state_t              state, state_next;
  logic [2:0]                  bit_cnt, cnt_next;
  logic [I2C_BYTE_W-1:0]       shift, shift_next;
  logic [I2C_BYTE_W-1:0]       byte_in;
  logic                        rw, rw_next;
  logic                        oe_next, we_next, busy_next, load_rd;
  logic [PTR_W-1:0]            addr_next;
  logic [7:0]                  wdata_next;

  // Control and output registers; everything returns to idle on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd0;
      sda_oe    <= 1'b0;
      rw        <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= cnt_next;
      sda_oe    <= oe_next;
      rw        <= rw_next;
      reg_we    <= we_next;
      reg_addr  <= addr_next;
      reg_wdata <= wdata_next;
      busy      <= busy_next;
    end
  end

  // Byte shift register; contents are meaningless between bytes so no reset
  always_ff @(posedge clk) begin
    shift <= shift_next;
  end

  // Next-state and datapath decode; START/STOP take priority over any state
  always_comb begin
    state_next = state;
    cnt_next   = bit_cnt;
    shift_next = shift;
    oe_next    = sda_oe;
    rw_next    = rw;
    we_next    = 1'b0;
    addr_next  = reg_addr;
    wdata_next = reg_wdata;
    load_rd    = 1'b0;
    byte_in    = {shift[6:0], sda_lvl};

    // Post-increment lands the clk after the strobe so reg_addr is stable with reg_we
    if (AUTOINC && reg_we) addr_next = reg_addr + PTR_W'(1);

    if (start_det) begin
      state_next = ST_ADDR;
      cnt_next   = 3'd0;
      oe_next    = 1'b0;
    end else if (stop_det) begin
      state_next = ST_IDLE;
      cnt_next   = 3'd0;
      oe_next    = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_next = byte_in;
            cnt_next   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              // General call (address 0) is never acknowledged
              if (byte_in[7:1] == SLAVE_ADDR && byte_in[7:1] != 7'd0) begin
                state_next = ST_ADDR_ACK;
                rw_next    = byte_in[0];
              end else begin
                state_next = ST_IDLE;
              end
            end
          end
        end
        ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_next = byte_in;
            cnt_next   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_PTR) begin
                addr_next  = byte_in[PTR_W-1:0];
                state_next = ST_PTR_ACK;
              end else begin
                wdata_next = byte_in;
                we_next    = 1'b1;
                state_next = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          // First fall pulls SDA low for the 9th bit, second fall ends it
          if (scl_fall) begin
            if (!sda_oe) begin
              oe_next = ~I2C_ACK;
            end else begin
              oe_next  = 1'b0;
              cnt_next = 3'd0;
              if (state == ST_ADDR_ACK && rw) begin
                state_next = ST_RDATA;
                load_rd    = 1'b1;
              end else if (state == ST_ADDR_ACK) begin
                state_next = ST_PTR;
              end else begin
                state_next = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            cnt_next = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_next = ST_RDATA_ACK;
          end else if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              load_rd = 1'b1;
            end else begin
              // Rotate rather than shift so the register keeps the whole byte
              shift_next = {shift[6:0], shift[7]};
              oe_next    = ~shift[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_fall) begin
            oe_next = 1'b0;
          end else if (scl_rise) begin
            cnt_next   = 3'd0;
            state_next = (sda_lvl == I2C_NACK) ? ST_IDLE : ST_RDATA;
          end
        end
        default: ;
      endcase
    end

    // Read byte load: sample register, drive its MSB, advance pointer
    if (load_rd) begin
      shift_next = reg_rdata;
      oe_next    = ~reg_rdata[7];
      if (AUTOINC) addr_next = reg_addr + PTR_W'(1);
    end

    busy_next = (state_next != ST_IDLE) && (state_next != ST_ADDR);
  end

endmodule
